// File: rtl/mopshub_sched_pkg.sv
// Shared defaults and FSM encoding for the 15:1 mux channel scheduler.
package mopshub_sched_pkg;

  localparam int N_CH_DEF    = 15;
  localparam int SEL_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_sel_scheduler_rr_pick.sv
// Combinational round-robin search: first set bit at or after ptr, wrapping at N_CH.
module rr_pick #(
  parameter int N_CH  = 15,
  parameter int SEL_W = 8
) (
  input  logic [N_CH-1:0]  req_vec,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] index
);

  int j;

  // Scan from the far end back toward ptr so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_CH) j = j - N_CH;
      if (req_vec[j]) begin
        found = 1'b1;
        index = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin scheduler driving the select code and load strobe of a 15:1 8-bit mux.
module mux_sel_scheduler
  import mopshub_sched_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic             en_sel,
  output logic [N_CH-1:0]  grant,
  output logic             busy,
  output logic             timeout_err
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [N_CH-1:0]  grant_d;
  logic             en_sel_d, busy_d, timeout_err_d;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    if (i == SEL_W'(N_CH - 1)) return '0;
    return i + SEL_W'(1);
  endfunction

  rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr_pick (
    .req_vec (req & ch_en),
    .ptr     (ptr_q),
    .found   (pick_found),
    .index   (pick_idx)
  );

  // sel doubles as the winner register; it is only rewritten on a new grant.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    sel_d         = sel;
    grant_d       = grant;
    en_sel_d      = 1'b0;
    busy_d        = busy;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_found) begin
          state_d  = ST_SELECT;
          sel_d    = pick_idx;
          grant_d  = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
          en_sel_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_SELECT: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (done || (cnt_q == 8'(TIMEOUT - 1))) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          busy_d        = 1'b0;
          cnt_d         = '0;
          ptr_d         = wrap_inc(sel);
          timeout_err_d = ~done;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sel         <= '0;
      grant       <= '0;
      en_sel      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sel         <= sel_d;
      grant       <= grant_d;
      en_sel      <= en_sel_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed and randomized checks of mux_sel_scheduler against a cycle-level behavioural model.
module tb_mux_sel_scheduler;

  localparam int N  = 15;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [14:0] req, ch_en;
  logic [7:0]  sel;
  logic        en_sel, busy, timeout_err;
  logic [14:0] grant;

  int checks = 0;
  int errors = 0;

  // behavioural model: phase 0 idle, 1 select, 2 wait
  int          ph = 0, m_ptr = 0, m_cnt = 0, m_sel = 0;
  logic [14:0] m_grant = '0;
  logic        m_en = 1'b0, m_busy = 1'b0, m_terr = 1'b0;

  int since = 100;
  int sel_log[$];
  bit saw14 = 1'b0;
  int terr_n = 0;

  always #5 clk = ~clk;

  mux_sel_scheduler #(.N_CH(N), .SEL_W(8), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ch_en       (ch_en),
    .done        (done),
    .sel         (sel),
    .en_sel      (en_sel),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [14:0] mask;
    bit found;
    int w;
    if (rst) begin
      ph = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
      m_grant = '0; m_en = 0; m_busy = 0; m_terr = 0;
    end else begin
      m_en = 0;
      m_terr = 0;
      case (ph)
        0: begin
          mask = req & ch_en;
          found = 0;
          w = 0;
          for (int k = 0; k < N; k++)
            if (!found && mask[(m_ptr + k) % N]) begin
              found = 1;
              w = (m_ptr + k) % N;
            end
          if (found) begin
            ph = 1; m_sel = w; m_grant = 15'(1) << w; m_en = 1; m_busy = 1;
          end
        end
        1: begin
          ph = 2; m_cnt = 0;
        end
        default: begin
          if (done || m_cnt == TO - 1) begin
            ph = 0; m_grant = '0; m_busy = 0;
            m_ptr = (m_sel + 1) % N;
            m_terr = !done;
          end else m_cnt++;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("sel", 32'(sel), 32'(m_sel));
    chk("en_sel", 32'(en_sel), 32'(m_en));
    chk("grant", 32'(grant), 32'(m_grant));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (en_sel === 1'b1) sel_log.push_back(int'(sel));
    if (grant[14] === 1'b1) saw14 = 1'b1;
    if (timeout_err === 1'b1) terr_n++;
    if (m_en) since = 0; else since++;
  endtask

  task automatic run(input int n, input int d_at);
    repeat (n) begin
      done = (since == d_at);
      tick();
    end
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    since = 100;
    sel_log.delete();
    saw14 = 1'b0;
    terr_n = 0;
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; req = '0; ch_en = 15'h7FFF;
    tick();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    do_reset();

    // single request, single grant, release by done
    req = 15'h0001;
    tick();
    chk("r033_en", 32'(en_sel), 32'h1);
    chk("r033_grant", 32'(grant), 32'h0001);
    req = '0;
    run(5, 3);
    chk("r033_idle_grant", 32'(grant), 32'h0);
    chk("r033_idle_busy", 32'(busy), 32'h0);

    // full round-robin sweep
    do_reset();
    req = 15'h7FFF;
    run(80, 3);
    chk("r034_len", 32'(sel_log.size()), 32'd16);
    for (int i = 0; i < sel_log.size(); i++) chk("r034_seq", 32'(sel_log[i]), 32'(i % N));

    // mask excludes channel 14
    do_reset();
    req = 15'h4001; ch_en = 15'h0001;
    run(40, 3);
    chk("r035_saw14", 32'(saw14), 32'h0);
    chk("r035_grants", 32'(sel_log.size() > 0), 32'h1);
    for (int i = 0; i < sel_log.size(); i++) chk("r035_sel", 32'(sel_log[i]), 32'h0);
    ch_en = 15'h7FFF;

    // timeout release and re-grant of the same channel
    do_reset();
    req = 15'h0020;
    run(12, 1000);
    chk("r036_terr_pulses", 32'(terr_n), 32'd2);
    chk("r036_grants", 32'(sel_log.size()), 32'd2);
    for (int i = 0; i < sel_log.size(); i++) chk("r036_sel", 32'(sel_log[i]), 32'd5);

    // done on the timeout cycle wins
    do_reset();
    req = 15'h0020;
    run(12, 4);
    chk("r037_terr_pulses", 32'(terr_n), 32'd0);

    // reset during WAIT on channel 9
    do_reset();
    req = 15'h0200;
    run(3, 1000);
    chk("r038_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r038_grant", 32'(grant), 32'h0);
    chk("r038_busy", 32'(busy), 32'h0);
    chk("r038_en", 32'(en_sel), 32'h0);
    req = 15'h0201;
    tick();
    chk("r038_regrant", 32'(sel), 32'h0);

    // randomized traffic, including done in IDLE/SELECT and stray resets
    for (int i = 0; i < 400; i++) begin
      req   = 15'($urandom);
      ch_en = 15'($urandom);
      done  = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
      chk("rand_sel_range", 32'(sel < 8'd15), 32'h1);
    end
    rst = 1'b0;
    done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
